// File: rtl/bin_to_temporal_encoder.sv
// Binary-time to edge-coded temporal encoder with gamma-cycle framing.
// A one-deep shadow set loads while the active set plays one gamma cycle.
module bin_to_temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
    parameter int MODE              = 0,
    parameter int VALUE_WIDTH       = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_times,
    input  logic [NUM_INPUTS-1:0]             in_present,
    input  logic [VALUE_WIDTH-1:0]            in_sel_time,
    input  logic                              in_sel_present,
    output logic                              grst,
    output logic [NUM_INPUTS-1:0]             temporal_out,
    output logic                              select_line,
    output logic                              cycle_active
);

    localparam int              PH_W    = $clog2(GAMMA_CYCLE_WIDTH + 1);
    localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(GAMMA_CYCLE_WIDTH);
    localparam logic            IDLE    = (MODE == 1) ? 1'b1 : 1'b0;

    logic [PH_W-1:0]                 r_phase;
    logic                            r_shadow_full;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] r_shadow_times;
    logic [NUM_INPUTS-1:0]           r_shadow_present;
    logic [VALUE_WIDTH-1:0]          r_shadow_sel_time;
    logic                            r_shadow_sel_present;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] r_act_times;
    logic [NUM_INPUTS-1:0]           r_act_present;
    logic [VALUE_WIDTH-1:0]          r_act_sel_time;
    logic                            r_act_sel_present;
    logic                            r_cycle_active;
    logic                            r_grst;
    logic [NUM_INPUTS-1:0]           r_temporal;
    logic                            r_select;

    logic [PH_W-1:0]                 w_phase_next;
    logic [PH_W-1:0]                 w_slot_next;
    logic                            w_transfer;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] w_nxt_times;
    logic [NUM_INPUTS-1:0]           w_nxt_present;
    logic [VALUE_WIDTH-1:0]          w_nxt_sel_time;
    logic                            w_nxt_sel_present;
    logic [NUM_INPUTS-1:0]           w_temporal_next;
    logic                            w_select_next;

    // Encoded level of one line in time slot i_k; out-of-range times count as no event.
    function automatic logic f_encode(input logic i_e, input logic [VALUE_WIDTH-1:0] i_v,
                                      input logic [PH_W-1:0] i_k);
        int   v_i;
        int   k_i;
        logic w_hit;
        v_i = int'(i_v);
        k_i = int'(i_k);
        if (!i_e || (v_i >= GAMMA_CYCLE_WIDTH)) begin
            w_hit = 1'b0;
        end else if (MODE == 2) begin
            w_hit = (k_i >= v_i) && (k_i < (v_i + PULSE_WIDTH));
        end else begin
            w_hit = (k_i >= v_i);
        end
        return (MODE == 1) ? ~w_hit : w_hit;
    endfunction

    assign in_ready   = !r_shadow_full || (r_phase == PH_ZERO);
    assign w_transfer = in_valid && in_ready;

    // Next phase, next active set (promotion at the framing slot) and next encoded outputs.
    always_comb begin
        w_phase_next      = (r_phase == PH_LAST) ? PH_ZERO : (r_phase + PH_ONE);
        w_slot_next       = w_phase_next - PH_ONE;
        w_nxt_times       = r_act_times;
        w_nxt_present     = r_act_present;
        w_nxt_sel_time    = r_act_sel_time;
        w_nxt_sel_present = r_act_sel_present;
        w_temporal_next   = {NUM_INPUTS{IDLE}};
        w_select_next     = IDLE;
        if (r_phase == PH_ZERO) begin
            if (r_shadow_full) begin
                w_nxt_times       = r_shadow_times;
                w_nxt_present     = r_shadow_present;
                w_nxt_sel_time    = r_shadow_sel_time;
                w_nxt_sel_present = r_shadow_sel_present;
            end else begin
                w_nxt_times       = '0;
                w_nxt_present     = '0;
                w_nxt_sel_time    = '0;
                w_nxt_sel_present = 1'b0;
            end
        end else begin
            w_nxt_times = r_act_times;
        end
        if (w_phase_next != PH_ZERO) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                w_temporal_next[i] = f_encode(w_nxt_present[i],
                                              w_nxt_times[i*VALUE_WIDTH +: VALUE_WIDTH],
                                              w_slot_next);
            end
            w_select_next = f_encode(w_nxt_sel_present, w_nxt_sel_time, w_slot_next);
        end else begin
            w_select_next = IDLE;
        end
    end

    // State, shadow/active operand sets and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase              <= PH_ZERO;
            r_shadow_full        <= 1'b0;
            r_shadow_times       <= '0;
            r_shadow_present     <= '0;
            r_shadow_sel_time    <= '0;
            r_shadow_sel_present <= 1'b0;
            r_act_times          <= '0;
            r_act_present        <= '0;
            r_act_sel_time       <= '0;
            r_act_sel_present    <= 1'b0;
            r_cycle_active       <= 1'b0;
            r_grst               <= 1'b1;
            r_temporal           <= {NUM_INPUTS{IDLE}};
            r_select             <= IDLE;
        end else begin
            r_phase           <= w_phase_next;
            r_act_times       <= w_nxt_times;
            r_act_present     <= w_nxt_present;
            r_act_sel_time    <= w_nxt_sel_time;
            r_act_sel_present <= w_nxt_sel_present;
            r_grst            <= (w_phase_next == PH_ZERO);
            r_temporal        <= w_temporal_next;
            r_select          <= w_select_next;
            if (r_phase == PH_ZERO) begin
                r_cycle_active <= r_shadow_full;
            end else if (r_phase == PH_LAST) begin
                r_cycle_active <= 1'b0;
            end else begin
                r_cycle_active <= r_cycle_active;
            end
            // A set taken during the framing slot replaces the one being promoted.
            if (w_transfer) begin
                r_shadow_full        <= 1'b1;
                r_shadow_times       <= in_times;
                r_shadow_present     <= in_present;
                r_shadow_sel_time    <= in_sel_time;
                r_shadow_sel_present <= in_sel_present;
            end else if (r_phase == PH_ZERO) begin
                r_shadow_full <= 1'b0;
            end else begin
                r_shadow_full <= r_shadow_full;
            end
        end
    end

    assign grst         = r_grst;
    assign temporal_out = r_temporal;
    assign select_line  = r_select;
    assign cycle_active = r_cycle_active;

endmodule

// File: doc/bin_to_temporal_encoder.md
Name: bin_to_temporal_encoder

Overview:
- Converts a vector of binary times into edge-coded temporal signals, one gamma cycle at a time.
- Also generates the gamma-cycle framing pulse `grst`.
- Sits directly upstream of the temporal mux / equal-gate fabric: drives its `inputs`, `select_line` and `grst`.
- Supports rising-edge, falling-edge and fixed-width-pulse encodings, with a one-deep shadow buffer so the next cycle's operands load while the current cycle plays out.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, number of time slots per gamma cycle (times 0..GAMMA_CYCLE_WIDTH-1).
- PULSE_WIDTH, 8, pulse length in clocks for MODE=2.
- NUM_INPUTS, GAMMA_CYCLE_WIDTH, number of data lanes.
- MODE, 0, encoding: 0 = rising edge, 1 = falling edge, 2 = pulse.
- VALUE_WIDTH, max(1,$clog2(GAMMA_CYCLE_WIDTH)), bits per time value.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  operand set can be accepted this cycle.
- in_times  in  NUM_INPUTS*VALUE_WIDTH  lane i time at bits [i*VALUE_WIDTH +: VALUE_WIDTH].
- in_present  in  NUM_INPUTS  1 = lane carries an event; 0 = no event (time "infinity").
- in_sel_time  in  VALUE_WIDTH  event time for select_line.
- in_sel_present  in  1  select_line carries an event.
- grst  out  1  gamma reset, high for the one framing clock of each gamma cycle.
- temporal_out  out  NUM_INPUTS  encoded lane signals.
- select_line  out  1  encoded select signal.
- cycle_active  out  1  current gamma cycle plays a loaded operand set.

Behaviour:
- Reset values: while rst is high and on the first clock after rst falls:
  - phase = 0, grst = 1.
  - temporal_out and select_line at idle level: 0 for MODE 0/2, all-ones for MODE 1.
  - shadow empty, active set cleared, cycle_active = 0.
- Phase counter p:
  - Cycles 0..GAMMA_CYCLE_WIDTH, then wraps to 0.
  - Gamma cycle length is GAMMA_CYCLE_WIDTH+1 clocks.
  - p=0 is the framing slot; p=k+1 is time slot k.
  - The counter is free-running after reset.
- All outputs are registered. The values below are those visible during the clock in which phase = p.
- p=0 (framing slot):
  - grst = 1; all encoded outputs at idle level.
  - If the shadow is full, it moves into the active set, the shadow clears, and cycle_active = 1 from p=1 through the next p=0 exclusive.
  - Otherwise the active set is cleared (no events) and cycle_active = 0.
- p=k+1, for each lane (and likewise select), with event time v and event flag e:
  - grst = 0.
  - MODE 0: out = e && (k >= v). Edge rises at slot v and holds to the end of the cycle.
  - MODE 1: out = !(e && (k >= v)). Falls at slot v.
  - MODE 2: out = e && (v <= k < v+PULSE_WIDTH). The pulse is truncated at the end of the cycle and never spans a framing slot.
  - A time value v >= GAMMA_CYCLE_WIDTH is treated as e=0.
- Handshake:
  - in_ready = !shadow_full || (p==0). Combinational from registered state only, never from in_valid.
  - Transfer occurs when in_valid && in_ready.
  - A set accepted at p=0 while the shadow is draining becomes the new shadow content. It plays next gamma cycle, not the one starting now.
  - A set accepted at p=0 into an empty shadow also waits one full gamma cycle; only shadow content present before the p=0 edge is promoted.
- Data stability: once accepted, operands are latched; changes on the in_* buses have no effect on the active or shadow sets.
- Backpressure: with the shadow full and p!=0, in_ready = 0 and offered data is ignored.
- Reset mid-cycle:
  - Outputs return to reset values on the next clock.
  - Shadow and active sets are discarded; no partial event is completed.

Test Plan:
- Reset, then idle 3 gamma cycles with no transfers -> grst high at clocks 0, 17 and 34 (GAMMA_CYCLE_WIDTH=16); temporal_out=0 throughout; cycle_active=0.
- MODE 0: load lane0 t=0, lane3 t=5, lane15 t=15, select t=5, others not present -> the next cycle but one plays them. lane0 high from p=1, lane3 and select high from p=6, lane15 high at p=16 only. All lanes return to 0 at the following p=0.
- MODE 2, PULSE_WIDTH=8: lane2 t=12 -> lane2 high for p=13..16 only (4 clocks, truncated); lane2 t=3 -> high for p=4..11 (8 clocks).
- MODE 1: lane1 t=7 and lane4 not present -> lane1 high for p=0..7 and low for p=8..16; lane4 high all cycle.
- Backpressure: hold in_valid=1 with distinct sets every clock -> exactly one transfer per gamma cycle, each at p=0 (in_ready is 0 at all other phases while the shadow is full). Each accepted set plays exactly once, in order.
- Reset asserted at p=9 with lane events pending -> next clock all outputs idle, grst=1, cycle_active=0. The first cycle after reset plays no events even though a set was previously in the shadow.
